// File: rtl/idwt53_pkg.sv
// Shared definitions for the LeGall 5/3 lifting datapaths.
// Holds the default coefficient width, the row-engine state enum and the
// update/predict helpers (sums carried in DATA_W+2 bits, results wrapped).
package idwt53_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int SUM_W      = DATA_W_DEF + 2;
    localparam int ROUND_UPD  = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    typedef logic signed [DATA_W_DEF-1:0] coef_t;
    typedef logic signed [SUM_W-1:0]      sum_t;

    function automatic sum_t sext(input coef_t v);
        return {{(SUM_W-DATA_W_DEF){v[DATA_W_DEF-1]}}, v};
    endfunction

    // x[2n] = s[n] - ((d_a + d_b + 2) >>> 2), wrapped to DATA_W
    function automatic coef_t lift_update(input coef_t s, input coef_t d_a, input coef_t d_b);
        sum_t t;
        t = sext(d_a) + sext(d_b) + sum_t'(ROUND_UPD);
        t = t >>> 2;
        t = sext(s) - t;
        return t[DATA_W_DEF-1:0];
    endfunction

    // x[2n-1] = d + ((x_a + x_b) >>> 1), wrapped to DATA_W
    function automatic coef_t lift_predict(input coef_t d, input coef_t x_a, input coef_t x_b);
        sum_t t;
        t = sext(x_a) + sext(x_b);
        t = t >>> 1;
        t = sext(d) + t;
        return t[DATA_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/idwt53_row_if.sv
// Coefficient-in / sample-out handshake bundle for idwt53_row.
// master: coefficient source + sample sink side; slave: the engine.
//   in_valid/in_ready/in_lo/in_hi/in_last      coefficient pair stream
//   out_valid/out_ready/out_even/out_odd/out_last  sample pair stream
interface idwt53_row_if #(
    parameter int DATA_W = idwt53_pkg::DATA_W_DEF
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_lo;
    logic signed [DATA_W-1:0] in_hi;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_even;
    logic signed [DATA_W-1:0] out_odd;
    logic                     out_last;

    modport master (
        output in_valid, in_lo, in_hi, in_last, out_ready,
        input  in_ready, out_valid, out_even, out_odd, out_last
    );

    modport slave (
        input  in_valid, in_lo, in_hi, in_last, out_ready,
        output in_ready, out_valid, out_even, out_odd, out_last
    );
endinterface

// File: rtl/lift53_inv_step.sv
// One combinational inverse 5/3 lifting step.
//   s, d_prev, d_cur : s[n], d[n-1], d[n]
//   x_prev           : x[2n-2]
//   flush            : row end; x_even_new is forced to x_prev so the
//                      predict gives d_prev + x_prev (x[2N] := x[2N-2])
//   x_even_new       : x[2n]
//   x_odd            : x[2n-1]
module lift53_inv_step
    import idwt53_pkg::*;
(
    input  coef_t s,
    input  coef_t d_prev,
    input  coef_t d_cur,
    input  coef_t x_prev,
    input  logic  flush,
    output coef_t x_even_new,
    output coef_t x_odd
);
    coef_t xe_upd;

    always_comb begin
        xe_upd     = lift_update(s, d_prev, d_cur);
        x_even_new = flush ? x_prev : xe_upd;
        x_odd      = lift_predict(d_prev, x_prev, x_even_new);
    end
endmodule

// File: rtl/idwt53_row.sv
// Streaming inverse LeGall 5/3 row reconstruction, one pair per cycle.
//   clk_fast : clock, all state on rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : idwt53_row_if slave (coefficient pairs in, sample pairs out)
module idwt53_row
    import idwt53_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk_fast,
    input  logic               rst_n,
    idwt53_row_if.slave        bus
);
    state_t state, state_nxt;

    logic signed [DATA_W-1:0] x_prev, x_prev_nxt;
    logic signed [DATA_W-1:0] d_prev, d_prev_nxt;
    logic signed [DATA_W-1:0] out_even, out_even_nxt;
    logic signed [DATA_W-1:0] out_odd, out_odd_nxt;
    logic                     out_valid, out_valid_nxt;
    logic                     out_last, out_last_nxt;

    logic signed [DATA_W-1:0] step_d_prev, step_d_cur, xe, xo;
    logic                     slot_free, accept, in_ready;

    assign slot_free = !out_valid || bus.out_ready;
    assign in_ready  = rst_n && (state != FLUSH) && slot_free;
    assign accept    = bus.in_valid && in_ready;

    // Pair 0 mirrors d[-1] := d[0]; FLUSH reuses d_prev for both taps.
    assign step_d_prev = (state == IDLE)  ? bus.in_hi : d_prev;
    assign step_d_cur  = (state == FLUSH) ? d_prev    : bus.in_hi;

    lift53_inv_step u_step (
        .s          (bus.in_lo),
        .d_prev     (step_d_prev),
        .d_cur      (step_d_cur),
        .x_prev     (x_prev),
        .flush      (state == FLUSH),
        .x_even_new (xe),
        .x_odd      (xo)
    );

    always_comb begin
        state_nxt     = state;
        x_prev_nxt    = x_prev;
        d_prev_nxt    = d_prev;
        out_even_nxt  = out_even;
        out_odd_nxt   = out_odd;
        out_last_nxt  = out_last;
        out_valid_nxt = out_valid && !bus.out_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    x_prev_nxt = xe;
                    d_prev_nxt = bus.in_hi;
                    state_nxt  = bus.in_last ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    out_even_nxt  = x_prev;
                    out_odd_nxt   = xo;
                    out_last_nxt  = 1'b0;
                    out_valid_nxt = 1'b1;
                    x_prev_nxt    = xe;
                    d_prev_nxt    = bus.in_hi;
                    state_nxt     = bus.in_last ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    out_even_nxt  = x_prev;
                    out_odd_nxt   = xo;
                    out_last_nxt  = 1'b1;
                    out_valid_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_prev    <= '0;
            d_prev    <= '0;
            out_even  <= '0;
            out_odd   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            x_prev    <= x_prev_nxt;
            d_prev    <= d_prev_nxt;
            out_even  <= out_even_nxt;
            out_odd   <= out_odd_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_even  = out_even;
    assign bus.out_odd   = out_odd;
    assign bus.out_last  = out_last;
endmodule
